// File: rtl/dpsk_pkg.sv
// Types and constants shared by the DPSK modulator and demodulator.
package dpsk_pkg;

    typedef enum logic [2:0] {
        GUARD,
        IDLE,
        START,
        DATA,
        STOP
    } dpsk_state_e;

    localparam logic START_SYM  = 1'b1;
    localparam logic STOP_SYM   = 1'b0;
    localparam int   DEF_WORD_W = 10;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/dpsk_demodulator.sv
// DPSK receiver: synchronise, mid-bit sample, XOR-decode and deframe LSB-first words.
//
// state | meaning
// GUARD | wait for CLKS_PER_BIT stable line cycles after reset
// IDLE  | track the line level, wait for an edge
// START | confirm the start edge at mid-bit
// DATA  | sample WORD_W data bits at mid-bit
// STOP  | sample the stop bit, publish word or flag error
module dpsk_demodulator
    import dpsk_pkg::*;
#(
    parameter int WORD_W       = DEF_WORD_W,
    parameter int CLKS_PER_BIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              line_in,
    output logic [WORD_W-1:0] word,
    output logic              word_valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(WORD_W + 1);

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);

    logic line_s;
    logic bit_now;

    dpsk_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              ref_q, ref_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              word_valid_q, word_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              busy_q, busy_d;

    sync_2ff u_sync_line (
        .clk (clk),
        .rst (rst),
        .d   (line_in),
        .q   (line_s)
    );

    assign bit_now = line_s ^ ref_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        ref_d        = ref_q;
        shreg_d      = shreg_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        busy_d       = busy_q;

        case (state_q)
            GUARD: begin
                ref_d  = line_s;
                busy_d = 1'b0;
                if (line_s != ref_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            IDLE: begin
                // ref keeps the pre-edge level so START can compare against it
                if (line_s != ref_q) begin
                    state_d = START;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end else begin
                    ref_d = line_s;
                end
            end
            START: begin
                if (cnt_q == CNT_MID) begin
                    cnt_d = '0;
                    if (bit_now == START_SYM) begin
                        ref_d   = line_s;
                        idx_d   = '0;
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    ref_d   = line_s;
                    shreg_d = {bit_now, shreg_q[WORD_W-1:1]};
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    ref_d   = line_s;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    if (bit_now == STOP_SYM) begin
                        word_d       = shreg_q;
                        word_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = GUARD;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= GUARD;
            cnt_q        <= '0;
            idx_q        <= '0;
            ref_q        <= 1'b0;
            shreg_q      <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            ref_q        <= ref_d;
            shreg_q      <= shreg_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    assign word       = word_q;
    assign word_valid = word_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;

endmodule
